log_afpm_serial: RTL and testbench
==================================

// Module: log_afpm_serial
// PURPOSE
//  Parametrised byte-serial Mitchell (logarithmic) approximate floating-point multiplier.
//  Generalises the fixed FP16 log multiplier to any EXP_W/MAN_W format and any bus width.
//  Operands A and B arrive LSB-beat first over two BUS_W lanes; the product leaves over one
//  BUS_W lane with ready/valid backpressure. Sits behind the TT pad mux (ui_in/uio_in/uo_out).
// PARAMETERS
//  EXP_W  5   exponent bits; BIAS = 2**(EXP_W-1)-1
//  MAN_W  10  stored mantissa bits; W = 1+EXP_W+MAN_W (default 16 = FP16)
//  BUS_W  8   beat width; BEATS = ceil(W/BUS_W); last beat zero-padded in MSBs
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      a_in/b_in hold a valid beat
//  in_ready   out  1      block accepts beats (IDLE or LOAD)
//  a_in       in   BUS_W  operand A beat
//  b_in       in   BUS_W  operand B beat
//  out_valid  out  1      out_data holds a result beat
//  out_ready  in   1      consumer takes beat when out_valid&out_ready
//  out_data   out  BUS_W  result beat, LSB beat first
//  out_last   out  1      high on final result beat
//  out_flags  out  3      {nan, overflow, underflow}; valid whenever out_valid
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, beat cnt=0, in_ready=1, out_valid=0, out_last=0, out_data=0, out_flags=0, busy=0.
//  rst dominates all other inputs every cycle; reset mid-load or mid-send drops the operation.
//  FSM: IDLE -(in_valid)-> LOAD (beat 0 stored) ; LOAD -(BEATS-th beat accepted)-> CALC ;
//   CALC -(1 cycle)-> SEND ; SEND -(last beat handshaken)-> IDLE.
//   If BEATS==1, IDLE goes straight to CALC. in_valid low in LOAD stalls; cnt holds.
//  Beat i fills bits [i*BUS_W +: BUS_W] of A and B. in_ready=0 in CALC and SEND.
//  CALC (comb on registered A,B, registered at end of cycle):
//   s = sa^sb; ea,eb unsigned; ma,mb MAN_W-bit fractions.
//   msum = ma+mb (MAN_W+1 bits); c = msum[MAN_W]; m = msum[MAN_W-1:0] (drop carry, truncate).
//   e = ea+eb-BIAS+c in EXP_W+2-bit signed arithmetic.
//  Specials, priority order:
//   1 either NaN, or Inf x zero -> canonical qNaN {0,all-ones,1,0..0}, nan=1.
//   2 either Inf -> {s,all-ones,0}.
//   3 either exp==0 (zero/subnormal, flushed) -> {s,0,0}.
//   4 e >= 2**EXP_W-1 -> {s,all-ones,0}, overflow=1.
//   5 e <= 0 -> {s,0,0}, underflow=1.
//   6 else {s,e[EXP_W-1:0],m}.
//  SEND: out_valid=1; beat k = R[k*BUS_W +: BUS_W]; k advances only on out_valid&out_ready;
//   out_data/out_last/out_flags stable while out_valid&!out_ready. out_last=1 on k==BEATS-1.
//  Latency (no stalls): first result beat valid 2 cycles after last input beat accepted.
//  Throughput: one op per BEATS+1+BEATS cycles; inputs not accepted during CALC/SEND.
// TESTING
//  1 FP16: A=0x44DF, B=0x483D, beats {DF,3D},{44,48} -> out 0x1C then 0x51 (last), flags 000.
//  2 A=B=0x3E00 (1.5) -> mantissa carry -> 0x4000, bytes 00,40, flags 000.
//  3 A=B=0x7BFF -> 0x7C00, overflow=1; A=0x0400,B=0x0400 -> 0x0000, underflow=1.
//  4 A=0x7C00,B=0x0000 -> 0x7E00 nan=1; A=0x8000,B=0x3C00 -> 0x8000; A=0xFC00,B=0x3C00 -> 0xFC00.
//  5 out_ready low 5 cycles in SEND, in_valid gap 3 cycles in LOAD -> beats held, no loss/dup, in_ready=0.
//  6 rst pulse mid-SEND -> next cycle out_valid=0, IDLE; EXP_W=8,MAN_W=23,BUS_W=8:
//    0x3FC00000 x 0x3FC00000 -> 0x40000000 over 4 beats.

Source files
------------

// File: rtl/log_afpm_serial.sv
// Byte-serial Mitchell (logarithmic) approximate floating-point multiplier.
// Operands stream in LSB beat first on two lanes; the product streams out with ready/valid.
module log_afpm_serial #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] a_in,
    input  logic [BUS_W-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_last,
    output logic [2:0]       out_flags,
    output logic             busy
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BEATS = (W + BUS_W - 1) / BUS_W;
    localparam int PW    = BEATS * BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EW    = EXP_W + 2;
    localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
    localparam int EMAX  = (2 ** EXP_W) - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_b;
    logic [PW-1:0]    r_res;

    logic                 w_sa, w_sb, w_s;
    logic [EXP_W-1:0]     w_ea, w_eb;
    logic [MAN_W-1:0]     w_ma, w_mb;
    logic [MAN_W:0]       w_msum;
    logic                 w_c;
    logic signed [EW-1:0] w_e;
    logic                 w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [W-1:0]         w_r;
    logic [PW-1:0]        w_res;
    logic [PW-1:0]        w_res_shift;
    logic [2:0]           w_flags;

    assign w_sa = r_a[W-1];
    assign w_sb = r_b[W-1];
    assign w_ea = r_a[W-2:MAN_W];
    assign w_eb = r_b[W-2:MAN_W];
    assign w_ma = r_a[MAN_W-1:0];
    assign w_mb = r_b[MAN_W-1:0];
    assign w_s  = w_sa ^ w_sb;

    // Mitchell approximation: adding log-domain mantissas; the carry bumps the exponent
    assign w_msum = {1'b0, w_ma} + {1'b0, w_mb};
    assign w_c    = w_msum[MAN_W];
    assign w_e    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb})
                  - $signed(EW'(BIAS)) + $signed({{(EW-1){1'b0}}, w_c});

    assign w_nan_a  = (w_ea == {EXP_W{1'b1}}) && (w_ma != {MAN_W{1'b0}});
    assign w_nan_b  = (w_eb == {EXP_W{1'b1}}) && (w_mb != {MAN_W{1'b0}});
    assign w_inf_a  = (w_ea == {EXP_W{1'b1}}) && (w_ma == {MAN_W{1'b0}});
    assign w_inf_b  = (w_eb == {EXP_W{1'b1}}) && (w_mb == {MAN_W{1'b0}});
    assign w_zero_a = (w_ea == {EXP_W{1'b0}});
    assign w_zero_b = (w_eb == {EXP_W{1'b0}});

    assign w_res_shift = r_res >> BUS_W;

    // Special-case resolution in priority order, then packing into the padded result word
    always_comb begin
        w_r     = {W{1'b0}};
        w_flags = 3'b000;
        w_res   = {PW{1'b0}};
        if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a)) begin
            w_r[W-2:MAN_W] = {EXP_W{1'b1}};
            w_r[MAN_W-1]   = 1'b1;
            w_flags        = 3'b100;
        end else if (w_inf_a || w_inf_b) begin
            w_r[W-1]       = w_s;
            w_r[W-2:MAN_W] = {EXP_W{1'b1}};
        end else if (w_zero_a || w_zero_b) begin
            w_r[W-1] = w_s;
        end else if (w_e >= $signed(EW'(EMAX))) begin
            w_r[W-1]       = w_s;
            w_r[W-2:MAN_W] = {EXP_W{1'b1}};
            w_flags        = 3'b010;
        end else if (w_e <= $signed({EW{1'b0}})) begin
            w_r[W-1] = w_s;
            w_flags  = 3'b001;
        end else begin
            w_r = {w_s, w_e[EXP_W-1:0], w_msum[MAN_W-1:0]};
        end
        w_res[W-1:0] = w_r;
    end

    // Control FSM with all handshake and data outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_a       <= {PW{1'b0}};
            r_b       <= {PW{1'b0}};
            r_res     <= {PW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= {BUS_W{1'b0}};
            out_flags <= 3'b000;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a[BUS_W-1:0] <= a_in;
                        r_b[BUS_W-1:0] <= b_in;
                        busy           <= 1'b1;
                        if (BEATS == 1) begin
                            r_state  <= S_CALC;
                            r_cnt    <= {CNT_W{1'b0}};
                            in_ready <= 1'b0;
                        end else begin
                            r_state  <= S_LOAD;
                            r_cnt    <= CNT_W'(1);
                            in_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_a[r_cnt*BUS_W +: BUS_W] <= a_in;
                        r_b[r_cnt*BUS_W +: BUS_W] <= b_in;
                        if (r_cnt == LAST_CNT) begin
                            r_state  <= S_CALC;
                            r_cnt    <= {CNT_W{1'b0}};
                            in_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_CALC: begin
                    r_res     <= w_res;
                    out_data  <= w_res[BUS_W-1:0];
                    out_flags <= w_flags;
                    out_last  <= (BEATS == 1);
                    out_valid <= 1'b1;
                    r_cnt     <= {CNT_W{1'b0}};
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_cnt == LAST_CNT) begin
                            r_state   <= S_IDLE;
                            r_cnt     <= {CNT_W{1'b0}};
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= {BUS_W{1'b0}};
                            out_flags <= 3'b000;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            // r_res is shifted so the next beat always sits in the low lane
                            r_res    <= w_res_shift;
                            out_data <= w_res_shift[BUS_W-1:0];
                            out_last <= ((r_cnt + CNT_W'(1)) == LAST_CNT);
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= {CNT_W{1'b0}};
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_data  <= {BUS_W{1'b0}};
                    out_flags <= 3'b000;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_afpm_serial.sv
// Directed self-checking bench for log_afpm_serial: FP16 default instance plus an FP32 instance.
module tb_log_afpm_serial;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] out_flags;
    logic       busy;

    logic       in_valid32;
    logic       in_ready32;
    logic [7:0] a32;
    logic [7:0] b32;
    logic       out_valid32;
    logic       out_ready32;
    logic [7:0] out_data32;
    logic       out_last32;
    logic [2:0] out_flags32;
    logic       busy32;

    int n_vec;
    int n_err;

    log_afpm_serial dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_flags(out_flags), .busy(busy)
    );

    log_afpm_serial #(.EXP_W(8), .MAN_W(23), .BUS_W(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a_in(a32), .b_in(b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_data(out_data32), .out_last(out_last32), .out_flags(out_flags32), .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load16(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = a[i*8 +: 8];
            b_in     = b[i*8 +: 8];
        end
    endtask

    task automatic collect16(output logic [15:0] r, output logic [2:0] fl,
                             output logic [1:0] lasts, output int waits, output logic tmo);
        int k;
        k = 0; waits = 0; tmo = 1'b1; r = 16'h0000; fl = 3'b000; lasts = 2'b00;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                r[k*8 +: 8] = out_data;
                lasts[k]    = out_last;
                if (k == 0) fl = out_flags;
                k++;
                if (k == 2) begin
                    tmo = 1'b0;
                    break;
                end
            end else if (k == 0) begin
                waits++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: got {rdy,vld,last,busy}=%b want 1000",
                     {in_ready, out_valid, out_last, busy});
        end
        n_vec++;
        if ({out_data, out_flags} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_data: got data=%h flags=%b want 00/000", out_data, out_flags);
        end
        n_vec++;
        if ({in_ready32, out_valid32, busy32} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_fp32: got {rdy,vld,busy}=%b want 100",
                     {in_ready32, out_valid32, busy32});
        end
        rst = 1'b0;
    endtask

    task automatic test_products();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [15:0] vr [8];
        logic [2:0]  vf [8];
        logic [15:0] r;
        logic [2:0]  fl;
        logic [1:0]  lasts;
        int          waits;
        logic        tmo;
        va[0] = 16'h44DF; vb[0] = 16'h483D; vr[0] = 16'h511C; vf[0] = 3'b000;
        va[1] = 16'h3E00; vb[1] = 16'h3E00; vr[1] = 16'h4000; vf[1] = 3'b000;
        va[2] = 16'h7BFF; vb[2] = 16'h7BFF; vr[2] = 16'h7C00; vf[2] = 3'b010;
        va[3] = 16'h0400; vb[3] = 16'h0400; vr[3] = 16'h0000; vf[3] = 3'b001;
        va[4] = 16'h7C00; vb[4] = 16'h0000; vr[4] = 16'h7E00; vf[4] = 3'b100;
        va[5] = 16'h8000; vb[5] = 16'h3C00; vr[5] = 16'h8000; vf[5] = 3'b000;
        va[6] = 16'hFC00; vb[6] = 16'h3C00; vr[6] = 16'hFC00; vf[6] = 3'b000;
        va[7] = 16'hC000; vb[7] = 16'h3C00; vr[7] = 16'hC000; vf[7] = 3'b000;
        for (int v = 0; v < 8; v++) begin
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL idle_ready[%0d]: got %b want 1", v, in_ready);
            end
            load16(va[v], vb[v]);
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if ({out_valid, in_ready, busy} !== 3'b001) begin
                n_err++;
                $display("FAIL calc_state[%0d]: got {vld,rdy,busy}=%b want 001",
                         v, {out_valid, in_ready, busy});
            end
            collect16(r, fl, lasts, waits, tmo);
            n_vec++;
            if (tmo !== 1'b0) begin
                n_err++;
                $display("FAIL timeout[%0d]: got no result want 2 beats", v);
            end
            n_vec++;
            if (r !== vr[v]) begin
                n_err++;
                $display("FAIL product[%0d] %h*%h: got %h want %h", v, va[v], vb[v], r, vr[v]);
            end
            n_vec++;
            if (fl !== vf[v]) begin
                n_err++;
                $display("FAIL flags[%0d]: got %b want %b", v, fl, vf[v]);
            end
            n_vec++;
            if (lasts !== 2'b10 || waits !== 0) begin
                n_err++;
                $display("FAIL last_latency[%0d]: got last=%b waits=%0d want 10/0", v, lasts, waits);
            end
            @(negedge clk);
            n_vec++;
            if ({out_valid, busy, in_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL back_idle[%0d]: got {vld,busy,rdy}=%b want 001",
                         v, {out_valid, busy, in_ready});
            end
        end
    endtask

    task automatic test_stalls();
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'hDF; b_in = 8'h3D;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            in_valid = 1'b0; a_in = 8'hAA; b_in = 8'h55;
            n_vec++;
            if ({in_ready, busy, out_valid} !== 3'b110) begin
                n_err++;
                $display("FAIL load_gap[%0d]: got {rdy,busy,vld}=%b want 110",
                         g, {in_ready, busy, out_valid});
            end
        end
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'h44; b_in = 8'h48;
        @(negedge clk);
        out_ready = 1'b0;
        a_in = 8'hFF; b_in = 8'hFF;
        @(negedge clk);
        for (int s = 0; s < 6; s++) begin
            if (s > 0) @(negedge clk);
            n_vec++;
            if ({out_valid, out_last, in_ready, out_data, out_flags} !== {3'b100, 8'h1C, 3'b000}) begin
                n_err++;
                $display("FAIL send_hold[%0d]: got vld=%b last=%b rdy=%b data=%h fl=%b want 1/0/0/1c/000",
                         s, out_valid, out_last, in_ready, out_data, out_flags);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_last, out_data} !== {2'b11, 8'h51}) begin
            n_err++;
            $display("FAIL send_beat1: got vld=%b last=%b data=%h want 1/1/51",
                     out_valid, out_last, out_data);
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_done: got {vld,busy}=%b want 00 (no duplicate beat)", {out_valid, busy});
        end
    endtask

    task automatic test_reset_mid_send();
        logic [15:0] r;
        logic [2:0]  fl;
        logic [1:0]  lasts;
        int          waits;
        logic        tmo;
        out_ready = 1'b0;
        load16(16'h44DF, 16'h483D);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_send: got vld=%b want 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, busy, in_ready, out_data, out_flags} !== {3'b001, 8'h00, 3'b000}) begin
            n_err++;
            $display("FAIL mid_send_reset: got vld=%b busy=%b rdy=%b data=%h fl=%b want 0/0/1/00/000",
                     out_valid, busy, in_ready, out_data, out_flags);
        end
        rst = 1'b0;
        load16(16'h3E00, 16'h3E00);
        @(negedge clk);
        in_valid = 1'b0;
        collect16(r, fl, lasts, waits, tmo);
        n_vec++;
        if (tmo !== 1'b0 || r !== 16'h4000 || fl !== 3'b000) begin
            n_err++;
            $display("FAIL after_reset_op: got r=%h fl=%b tmo=%b want 4000/000/0", r, fl, tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_fp32();
        logic [31:0] a;
        logic [31:0] r;
        logic [3:0]  lasts;
        int          k;
        a = 32'h3FC00000;
        r = 32'h0; lasts = 4'h0; k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid32 = 1'b1;
            a32 = a[i*8 +: 8];
            b32 = a[i*8 +: 8];
        end
        @(negedge clk);
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid32) begin
                r[k*8 +: 8] = out_data32;
                lasts[k]    = out_last32;
                k++;
                if (k == 4) break;
            end
        end
        n_vec++;
        if (k !== 4 || r !== 32'h40000000) begin
            n_err++;
            $display("FAIL fp32_product: got %h beats=%0d want 40000000 beats=4", r, k);
        end
        n_vec++;
        if (lasts !== 4'b1000 || out_flags32 !== 3'b000) begin
            n_err++;
            $display("FAIL fp32_last: got last=%b fl=%b want 1000/000", lasts, out_flags32);
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid32, busy32} !== 2'b00) begin
            n_err++;
            $display("FAIL fp32_idle: got {vld,busy}=%b want 00", {out_valid32, busy32});
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = 8'h00; b32 = 8'h00; out_ready32 = 1'b1;
        test_reset();
        test_products();
        test_stalls();
        test_reset_mid_send();
        test_fp32();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
